// File: rtl/fazy_rozrzadu_pasmowe.sv
// Band-scheduled valve/injection/spark angle slewing with hysteretic rpm band select.
// Optional FAZY_TDC_SYNC_EN: band changes only on tdc pulses (once per engine cycle).
module fazy_slew_lane #(
    parameter int W = 10,
    parameter int STEP = 4,
    parameter logic [W-1:0] RST = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic [W-1:0] tgt,
    output logic [W-1:0] cur,
    output logic         at_tgt
);
    localparam logic [W:0] FULL = (W+1)'(720);
    localparam logic [W:0] HALF = (W+1)'(360);
    localparam logic [W:0] STP  = (W+1)'(STEP);

    logic [W:0] c1, t1, d, r, mv, sum;
    logic [W-1:0] nxt;

    always_comb begin
        c1  = {1'b0, cur};
        t1  = {1'b0, tgt};
        d   = (t1 >= c1) ? t1 - c1 : t1 + FULL - c1;
        r   = FULL - d;
        mv  = '0;
        sum = '0;
        nxt = cur;
        if (tick && d != '0) begin
            // d == 360 is a tie and goes upward
            if (d <= HALF) begin
                mv  = (d < STP) ? d : STP;
                sum = c1 + mv;
                nxt = (sum >= FULL) ? W'(sum - FULL) : W'(sum);
            end else begin
                mv  = (r < STP) ? r : STP;
                nxt = (c1 >= mv) ? W'(c1 - mv) : W'(c1 + FULL - mv);
            end
        end
        at_tgt = (nxt == tgt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= RST;
        else        cur <= nxt;
    end
endmodule

module fazy_rozrzadu_pasmowe #(
    parameter int W = 10,
    parameter int RPM_W = 7,
    parameter int BANDS = 4,
    parameter int CH = 8,
    parameter logic [(BANDS-1)*RPM_W-1:0] BAND_TH = {7'd90, 7'd70, 7'd50},
    parameter int HYST = 2,
    parameter int STEP = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [RPM_W-1:0]             rpm,
    input  logic                         tick,
    input  logic                         tdc,
    input  logic                         cfg_we,
    input  logic [$clog2(BANDS*CH)-1:0]  cfg_addr,
    input  logic [W-1:0]                 cfg_data,
    output logic                         cfg_err,
    output logic [$clog2(BANDS)-1:0]     band,
    output logic [CH*W-1:0]              angle_out,
    output logic                         settled
);
    localparam int AW = $clog2(BANDS*CH);
    localparam int BW = $clog2(BANDS);
    localparam int N  = BANDS*CH;

    // Power-on calibration: band 0 row, and a shared row for all higher bands.
    function automatic logic [W-1:0] dflt(input int b, input int c);
        int r0 [8] = '{160, 406, 674, 190, 170, 250, 525, 545};
        int r1 [8] = '{140, 426, 654, 170, 150, 250, 515, 555};
        return (b == 0) ? W'(r0[c % 8]) : W'(r1[c % 8]);
    endfunction

    function automatic logic [RPM_W:0] th(input logic [BW-1:0] k);
        int i;
        i = (int'(k) < BANDS-1) ? int'(k) : BANDS-2;
        return {1'b0, BAND_TH[i*RPM_W +: RPM_W]};
    endfunction

    logic [W-1:0]        tbl [N];
    logic [CH-1:0][W-1:0] tgt, cur;
    logic [CH-1:0]       at;
    logic [BW-1:0]       band_d;
    logic [RPM_W:0]      rpm1;
    logic                eval, wr_ok;
    logic [AW:0]         addr1;

`ifdef FAZY_TDC_SYNC_EN
    assign eval = tdc;
`else
    logic unused_tdc;
    assign unused_tdc = tdc;
    assign eval = 1'b1;
`endif

    assign rpm1 = {1'b0, rpm};

    always_comb begin
        band_d = band;
        if (eval) begin
            if (int'(band) < BANDS-1 && rpm1 >= th(band) + (RPM_W+1)'(HYST))
                band_d = band + 1'b1;
            else if (band != '0 && rpm1 + (RPM_W+1)'(HYST) < th(band - 1'b1))
                band_d = band - 1'b1;
        end
    end

    assign addr1 = {1'b0, cfg_addr};
    assign wr_ok = (addr1 < (AW+1)'(N)) && (cfg_data <= W'(719));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            band    <= '0;
            cfg_err <= 1'b0;
            settled <= 1'b1;
            for (int i = 0; i < N; i++) tbl[i] <= dflt(i / CH, i % CH);
        end else begin
            band    <= band_d;
            cfg_err <= cfg_we && !wr_ok;
            settled <= &at;
            if (cfg_we && wr_ok) tbl[cfg_addr] <= cfg_data;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        assign tgt[c] = tbl[int'(band)*CH + c];
        fazy_slew_lane #(.W(W), .STEP(STEP), .RST(dflt(0, c))) u_lane (
            .clk(clk), .rst_n(rst_n), .tick(tick),
            .tgt(tgt[c]), .cur(cur[c]), .at_tgt(at[c])
        );
        assign angle_out[c*W +: W] = cur[c];
    end
endmodule
